// File: rtl/roman_pkg.sv
// Shared symbol codes, FSM state codes and symbol-value lookup for the Roman decoder.
package roman_pkg;

  localparam logic [2:0] SYM_NULL = 3'b000;
  localparam logic [2:0] SYM_I    = 3'b001;
  localparam logic [2:0] SYM_V    = 3'b010;
  localparam logic [2:0] SYM_X    = 3'b011;
  localparam logic [2:0] SYM_L    = 3'b100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [5:0] sym_val(input logic [2:0] sym);
    case (sym)
      SYM_I:   return 6'd1;
      SYM_V:   return 6'd5;
      SYM_X:   return 6'd10;
      SYM_L:   return 6'd50;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/roman2bin_serial_if.sv
// Symbol input stream and result output stream of the Roman decoder.
interface roman2bin_serial_if #(
  parameter int unsigned VAL_WIDTH = 6,
  parameter int unsigned SYM_WIDTH = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SYM_WIDTH-1:0] in_sym;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [VAL_WIDTH-1:0] out_val;
  logic                 out_err;

  modport master (
    output in_valid, in_sym, in_last, out_ready,
    input  in_ready, out_valid, out_val, out_err
  );

  modport slave (
    input  in_valid, in_sym, in_last, out_ready,
    output in_ready, out_valid, out_val, out_err
  );
endinterface

// File: rtl/roman_sym_check.sv
// Canonical-form tracker: flags a non-NULL legal symbol that breaks standard Roman notation.
module roman_sym_check
  import roman_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic       i_clear,
  input  logic [2:0] i_sym,
  output logic       o_err
);

  logic [2:0] r_prev;
  logic [2:0] r_pprev;
  logic [2:0] r_pair_pre;
  logic [1:0] r_run;
  logic       r_pair;

  logic w_sub, w_five, w_rep_err, w_pair_err, w_after_err, w_pred_err;

  // Codes are ordered by value, so code comparisons stand in for value comparisons.
  assign w_sub  = (r_prev != SYM_NULL) && (i_sym > r_prev);
  assign w_five = (i_sym == SYM_V) || (i_sym == SYM_L);

  assign w_rep_err  = (i_sym == r_prev) && (w_five || (r_run == 2'd3));
  assign w_pair_err = w_sub && ((r_run > 2'd1) ||
                      !(((r_prev == SYM_I) && ((i_sym == SYM_V) || (i_sym == SYM_X))) ||
                        ((r_prev == SYM_X) && (i_sym == SYM_L))));
  assign w_after_err = r_pair && (i_sym >= r_pair_pre);
  assign w_pred_err  = w_sub && (r_pprev != SYM_NULL) &&
                       ((r_pprev < i_sym) || ((r_pprev == i_sym) && w_five));

  assign o_err = i_valid && (w_rep_err || w_pair_err || w_after_err || w_pred_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev     <= SYM_NULL;
      r_pprev    <= SYM_NULL;
      r_pair_pre <= SYM_NULL;
      r_run      <= 2'd0;
      r_pair     <= 1'b0;
    end else if (i_clear) begin
      r_prev     <= SYM_NULL;
      r_pprev    <= SYM_NULL;
      r_pair_pre <= SYM_NULL;
      r_run      <= 2'd0;
      r_pair     <= 1'b0;
    end else if (i_valid) begin
      r_pprev    <= r_prev;
      r_prev     <= i_sym;
      r_pair     <= w_sub;
      r_pair_pre <= r_prev;
      if (i_sym == r_prev) begin
        r_run <= (r_run == 2'd3) ? 2'd3 : r_run + 2'd1;
      end else begin
        r_run <= 2'd1;
      end
    end
  end

endmodule

// File: rtl/roman2bin_serial.sv
// Serial Roman-numeral to binary decoder over valid/ready streams.
// Define ROMAN_STRICT_CHECK_EN to also reject non-canonical numerals.
module roman2bin_serial
  import roman_pkg::*;
#(
  parameter int unsigned VAL_WIDTH = 6,
  parameter int unsigned SYM_WIDTH = 3,
  parameter int unsigned MAX_SYM   = 6,
  parameter int unsigned ACC_WIDTH = 9
) (
  input logic               clk,
  input logic               rst,
  roman2bin_serial_if.slave bus
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_SYM + 2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_SYM);
  localparam logic [ACC_WIDTH-1:0] MAX_VAL = ACC_WIDTH'((1 << VAL_WIDTH) - 1);

  logic [1:0]           r_state;
  logic [ACC_WIDTH-1:0] r_acc, w_acc_d;
  logic [2:0]           r_prev, w_prev_d;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_d;
  logic                 r_err, w_err_d;
  logic [VAL_WIDTH-1:0] r_out_val;
  logic                 r_out_err;

  logic [SYM_WIDTH-1:0] w_sym;
  logic [ACC_WIDTH-1:0] w_v, w_p;
  logic w_in_fire, w_out_fire, w_sym_ill, w_sym_use, w_chk_err, w_res_err;

  assign w_sym         = bus.in_sym;
  assign bus.in_ready  = (r_state != ST_DONE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_val   = r_out_val;
  assign bus.out_err   = r_out_err;

  assign w_in_fire  = bus.in_valid && bus.in_ready;
  assign w_out_fire = bus.out_valid && bus.out_ready;
  assign w_sym_ill  = (w_sym > SYM_WIDTH'(SYM_L));
  assign w_sym_use  = w_in_fire && !w_sym_ill && (w_sym != '0);
  assign w_v        = ACC_WIDTH'(sym_val(w_sym[2:0]));
  assign w_p        = ACC_WIDTH'(sym_val(r_prev));

`ifdef ROMAN_STRICT_CHECK_EN
  roman_sym_check u_sym_check (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_sym_use),
    .i_clear (w_out_fire),
    .i_sym   (w_sym[2:0]),
    .o_err   (w_chk_err)
  );
`else
  assign w_chk_err = 1'b0;
`endif

  always_comb begin
    w_acc_d  = r_acc;
    w_prev_d = r_prev;
    w_cnt_d  = r_cnt;
    w_err_d  = r_err;
    if (w_sym_use) begin
      // A larger symbol after a smaller one undoes the earlier add and subtracts instead.
      if ((w_v > w_p) && (w_p != '0)) begin
        w_acc_d = r_acc + w_v - (w_p << 1);
      end else begin
        w_acc_d = r_acc + w_v;
      end
      w_prev_d = w_sym[2:0];
      w_cnt_d  = (r_cnt > CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      if (w_cnt_d > CNT_MAX) w_err_d = 1'b1;
      if (w_chk_err) w_err_d = 1'b1;
    end
    if (w_in_fire && w_sym_ill) w_err_d = 1'b1;
  end

  assign w_res_err = w_err_d || (w_acc_d > MAX_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_prev    <= SYM_NULL;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_out_val <= '0;
      r_out_err <= 1'b0;
    end else if (w_out_fire) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_prev    <= SYM_NULL;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_out_val <= '0;
      r_out_err <= 1'b0;
    end else if (w_in_fire) begin
      r_acc  <= w_acc_d;
      r_prev <= w_prev_d;
      r_cnt  <= w_cnt_d;
      r_err  <= w_err_d;
      if (bus.in_last) begin
        r_state   <= ST_DONE;
        r_out_val <= w_res_err ? '0 : w_acc_d[VAL_WIDTH-1:0];
        r_out_err <= w_res_err;
      end else begin
        r_state <= ST_ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_roman2bin_serial.sv
// Self-checking bench for roman2bin_serial: directed cases plus random numerals vs a reference model.
module tb_roman2bin_serial;

  localparam logic [2:0] N = 3'd0;
  localparam logic [2:0] I = 3'd1;
  localparam logic [2:0] V = 3'd2;
  localparam logic [2:0] X = 3'd3;
  localparam logic [2:0] L = 3'd4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  roman2bin_serial_if bus_if ();

  roman2bin_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] num_q[$];
  logic [2:0] canon_q[$];
  int         exp_val;
  logic       exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sym_value(input logic [2:0] s);
    case (s)
      3'd1:    return 1;
      3'd2:    return 5;
      3'd3:    return 10;
      3'd4:    return 50;
      default: return 0;
    endcase
  endfunction

  // Standard greedy Roman spelling of n.
  function automatic void build_canon(input int n);
    int         tv[7] = '{50, 40, 10, 9, 5, 4, 1};
    logic [2:0] ta[7] = '{L, X, X, I, V, I, I};
    logic [2:0] tb[7] = '{N, L, N, X, N, V, N};
    int         rem = n;
    canon_q = {};
    for (int k = 0; k < 7; k++) begin
      while (rem >= tv[k]) begin
        canon_q.push_back(ta[k]);
        if (tb[k] != N) canon_q.push_back(tb[k]);
        rem -= tv[k];
      end
    end
  endfunction

  // Textbook rule: a symbol smaller than its successor is subtracted, otherwise added.
  function automatic void model();
    logic [2:0] syms[$];
    int         v;
    bit         bad;
    syms = {};
    bad  = 1'b0;
    foreach (num_q[k]) begin
      if (num_q[k] > L) bad = 1'b1;
      else if (num_q[k] != N) syms.push_back(num_q[k]);
    end
    if (syms.size() > 6) bad = 1'b1;
    v = 0;
    for (int k = 0; k < syms.size(); k++) begin
      if ((k + 1 < syms.size()) && (sym_value(syms[k]) < sym_value(syms[k+1])))
        v -= sym_value(syms[k]);
      else
        v += sym_value(syms[k]);
    end
    if ((v > 63) || (v < 0)) bad = 1'b1;
`ifdef ROMAN_STRICT_CHECK_EN
    if (!bad) begin
      build_canon(v);
      if (canon_q.size() != syms.size()) bad = 1'b1;
      else foreach (syms[k]) if (syms[k] != canon_q[k]) bad = 1'b1;
    end
`endif
    exp_err = bad;
    exp_val = bad ? 0 : v;
  endfunction

  task automatic send_sym(input logic [2:0] s, input logic last);
    int n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_sym   = s;
    bus_if.in_last  = last;
    while (!bus_if.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 32'(bus_if.in_ready), 32'd1);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic send_numeral(input int max_gap);
    for (int k = 0; k < num_q.size(); k++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      send_sym(num_q[k], k == num_q.size() - 1);
    end
  endtask

  task automatic get_result(input string tag, input int hold);
    int n = 0;
    while (!bus_if.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
    check({tag, "_busy"}, 32'(bus_if.in_ready), 32'd0);
    check({tag, "_val"}, 32'(bus_if.out_val), 32'(exp_val));
    check({tag, "_err"}, 32'(bus_if.out_err), 32'(exp_err));
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      check({tag, "_hold_val"}, 32'(bus_if.out_val), 32'(exp_val));
      check({tag, "_hold_err"}, 32'(bus_if.out_err), 32'(exp_err));
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    check({tag, "_released"}, 32'(bus_if.out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus_if.in_ready), 32'd1);
  endtask

  task automatic run_case(input string tag, input int max_gap, input int hold);
    model();
    send_numeral(max_gap);
    get_result(tag, hold);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_sym    = N;
    bus_if.in_last   = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_out_val", 32'(bus_if.out_val), 32'd0);
    check("rst_out_err", 32'(bus_if.out_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // XLIX with consumer always ready: result one cycle after last symbol
    num_q = '{X, L, I, X};
    model();
    bus_if.out_ready = 1'b1;
    send_numeral(0);
    check("xlix_latency", 32'(bus_if.out_valid), 32'd1);
    get_result("xlix", 0);

    num_q = '{N, N, L, X, I, I};
    run_case("pad62", 0, 0);
    num_q = '{L, X, I, V};
    run_case("range64", 0, 0);

    // Result held under back-pressure while next symbol waits
    num_q = '{I, V};
    model();
    send_numeral(0);
    bus_if.in_valid = 1'b1;
    bus_if.in_sym   = X;
    bus_if.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(bus_if.out_valid), 32'd1);
      check("bp_val", 32'(bus_if.out_val), 32'd4);
      check("bp_blocked", 32'(bus_if.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    check("bp_ready_back", 32'(bus_if.in_ready), 32'd1);
    check("bp_no_bypass", 32'(bus_if.out_valid), 32'd0);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    num_q = '{X};
    model();
    get_result("bp_next", 0);

    num_q = '{I, I, I, I, I, I, I};
    run_case("seven_i", 0, 0);
    num_q = '{X, 3'b110, I};
    run_case("illegal", 0, 0);
    num_q = '{I, I, I, I};
    run_case("iiii", 0, 0);
    num_q = '{X, I, X};
    run_case("xix", 0, 0);
    num_q = '{I, X, I};
    run_case("ixi", 0, 0);
    num_q = '{N, N, N};
    run_case("nulls", 0, 0);

    // Reset mid-numeral discards the partial value
    send_sym(X, 1'b0);
    send_sym(X, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    check("abort_valid", 32'(bus_if.out_valid), 32'd0);
    check("abort_ready", 32'(bus_if.in_ready), 32'd1);
    @(posedge clk); #1;
    check("abort_no_out", 32'(bus_if.out_valid), 32'd0);
    num_q = '{I};
    run_case("after_abort", 0, 0);

    for (int t = 0; t < 60; t++) begin
      num_q = {};
      if ($urandom_range(1, 0) == 1) begin
        build_canon(int'($urandom_range(63, 1)));
        foreach (canon_q[k]) begin
          if ($urandom_range(4, 0) == 0) num_q.push_back(N);
          num_q.push_back(canon_q[k]);
        end
      end else begin
        int len = int'($urandom_range(7, 1));
        for (int k = 0; k < len; k++) begin
          int r = int'($urandom_range(19, 0));
          if (r == 0)     num_q.push_back(3'($urandom_range(7, 5)));
          else if (r < 4) num_q.push_back(N);
          else            num_q.push_back(3'($urandom_range(4, 1)));
        end
      end
      run_case("rand", 2, int'($urandom_range(3, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
